pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, optional skid buffer and synchronous flush. It generalises the fixed EX/MEM latch to any payload width. It adds a control sub-field that is zeroed whenever the stage holds no valid beat. It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the global stall wiring with per-stage back-pressure.

## Interface
- DATA_W, 69, width of the data payload (e.g. ALU result 32 + store data 32 + rd 5)
- CTRL_W, 4, width of the control payload (e.g. MemToReg, RegWrite, MemWrite, MemRead); forced to 0 when the stage is not valid
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage accepts a beat this cycle
- in_data_i  in  DATA_W  upstream data payload
- in_ctrl_i  in  CTRL_W  upstream control payload
- flush_i  in  1  synchronous kill of all held and incoming beats
- out_valid_o  out  1  downstream beat valid
- out_ready_i  in  1  downstream accepts the beat
- out_data_o  out  DATA_W  registered data payload
- out_ctrl_o  out  CTRL_W  registered control payload, 0 when out_valid_o=0
- occ_o  out  2  entries held (0, 1 or 2)

## Operation
- Transfers: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- States for SKID_EN=1: EMPTY (occ 0), FULL (main register valid, occ 1), SKID (main and skid registers valid, occ 2).
- EMPTY: in_fire loads main and goes to FULL.
- FULL:
  - in_fire & out_fire: main reloads, stays FULL.
  - in_fire & !out_fire: beat goes to the skid register, next state SKID.
  - !in_fire & out_fire: next state EMPTY.
  - Neither: hold.
- SKID: in_ready_o=0. out_fire moves skid to main, next state FULL. Otherwise hold.
- SKID_EN=1: in_ready_o = (state != SKID), driven directly from a flop.
- SKID_EN=0: only EMPTY and FULL exist. in_ready_o = !out_valid_o | out_ready_i (combinational). occ_o never reads 2.
- Flush (highest priority):
  - Next state is EMPTY and out_ctrl_o is cleared to 0.
  - Any in_fire in the flush cycle is discarded.
  - out_data_o holds its last value.
- On EMPTY entry by drain, out_ctrl_o clears to 0 and out_data_o holds.
- The payload is never modified. Beats leave in order, with no loss and no duplication.

## Timing
- Reset (asynchronous, while rst_i=0): state EMPTY, out_valid_o=0, out_data_o=0, out_ctrl_o=0, skid register=0, occ_o=0. in_ready_o=1 in both modes.
- Latency: in_fire at edge N gives out_valid_o=1 with that payload after edge N, so the beat is visible in cycle N+1.
- Throughput: 1 beat/cycle with out_ready_i held at 1, in both modes.
- Stall with SKID_EN=1: when out_ready_i drops, at most 1 extra beat is absorbed. in_ready_o falls in the cycle after the skid register loads.
- Simultaneous flush_i and out_fire: the downstream has consumed the beat this cycle. The stage still ends EMPTY.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Held beats are lost.
- Deassertion of rst_i is synchronised externally. The first in_fire is permitted on the first edge after deassertion.

## Test plan
- Reset: hold rst_i=0 with random inputs. Required: out_valid_o=0, out_data_o=0, out_ctrl_o=0, occ_o=0, in_ready_o=1. Assert rst_i=0 mid-stream in SKID: all outputs clear asynchronously.
- Streaming: send data 0x1..0x10 with ctrl 4'b1010, out_ready_i=1. Required:
  - The same 16 beats appear in order, each 1 cycle after acceptance.
  - out_valid_o stays high for 16 consecutive cycles.
  - occ_o=1 throughout.
- Skid (SKID_EN=1): stream 0xA0, 0xA1, 0xA2, …, drop out_ready_i for 3 cycles. Required:
  - 0xA1 is held in the skid register and occ_o=2.
  - in_ready_o=0 until out_ready_i rises.
  - Output order is 0xA0, 0xA1, 0xA2 with no gaps once ready returns.
- Flush in SKID with in_valid_i=1 carrying 0xBB. Required:
  - Next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0.
  - 0xBB never appears at the output.
  - in_ready_o=1.
- Simultaneous flush and out_fire in FULL holding 0x55/ctrl 4'b0110. Required:
  - 0x55 is counted exactly once downstream.
  - Next cycle occ_o=0 and out_ctrl_o=0, out_data_o still 0x55.
- SKID_EN=0 with out_ready_i=0 and state FULL. Required:
  - in_ready_o=0 in the same cycle.
  - Raising out_ready_i with in_valid_i=1 gives in_ready_o=1 in the same cycle and replaces the beat on the next edge.
  - occ_o never equals 2.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid buffer
// and synchronous flush; the control payload reads zero whenever no beat is held.
module pipe_stage_skid #(
    parameter int DATA_W  = 69,
    parameter int CTRL_W  = 4,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    logic              out_valid_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [1:0]        occ_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_q & out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = main_ctrl;
    assign occ_o       = occ_q;

    generate
        if (SKID_EN) begin : g_skid
            logic              ready_q;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Ready comes straight from a flop so no combinational path runs back upstream.
            assign in_ready_o = ready_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    main_data   <= '0;
                    main_ctrl   <= '0;
                    skid_data   <= '0;
                    skid_ctrl   <= '0;
                    ready_q     <= 1'b1;
                    occ_q       <= 2'd0;
                end else if (flush_i) begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    main_ctrl   <= '0;
                    ready_q     <= 1'b1;
                    occ_q       <= 2'd0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                main_data   <= in_data_i;
                                main_ctrl   <= in_ctrl_i;
                                out_valid_q <= 1'b1;
                                occ_q       <= 2'd1;
                                state       <= FULL;
                            end
                        end
                        FULL: begin
                            if (in_fire && out_fire) begin
                                main_data <= in_data_i;
                                main_ctrl <= in_ctrl_i;
                            end else if (in_fire) begin
                                // Downstream stalled: park the extra beat and close the gate.
                                skid_data <= in_data_i;
                                skid_ctrl <= in_ctrl_i;
                                ready_q   <= 1'b0;
                                occ_q     <= 2'd2;
                                state     <= SKID;
                            end else if (out_fire) begin
                                out_valid_q <= 1'b0;
                                main_ctrl   <= '0;
                                occ_q       <= 2'd0;
                                state       <= EMPTY;
                            end
                        end
                        SKID: begin
                            if (out_fire) begin
                                main_data <= skid_data;
                                main_ctrl <= skid_ctrl;
                                ready_q   <= 1'b1;
                                occ_q     <= 2'd1;
                                state     <= FULL;
                            end
                        end
                        default: begin
                            state       <= EMPTY;
                            out_valid_q <= 1'b0;
                            main_ctrl   <= '0;
                            ready_q     <= 1'b1;
                            occ_q       <= 2'd0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Without a skid entry the stage may only accept when its beat leaves this cycle.
            assign in_ready_o = ~out_valid_q | out_ready_i;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    main_data   <= '0;
                    main_ctrl   <= '0;
                    occ_q       <= 2'd0;
                end else if (flush_i) begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    main_ctrl   <= '0;
                    occ_q       <= 2'd0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                main_data   <= in_data_i;
                                main_ctrl   <= in_ctrl_i;
                                out_valid_q <= 1'b1;
                                occ_q       <= 2'd1;
                                state       <= FULL;
                            end
                        end
                        FULL: begin
                            if (in_fire) begin
                                main_data <= in_data_i;
                                main_ctrl <= in_ctrl_i;
                            end else if (out_fire) begin
                                out_valid_q <= 1'b0;
                                main_ctrl   <= '0;
                                occ_q       <= 2'd0;
                                state       <= EMPTY;
                            end
                        end
                        default: begin
                            state       <= EMPTY;
                            out_valid_q <= 1'b0;
                            main_ctrl   <= '0;
                            occ_q       <= 2'd0;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid-mode and one single-register instance,
// each tracked by a payload scoreboard plus directed state checks.
module tb_pipe_stage_skid;

    localparam int DATA_W = 69;
    localparam int CTRL_W = 4;
    localparam int BEAT_W = DATA_W + CTRL_W;

    logic              clk;
    logic              rst;

    logic              s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [DATA_W-1:0] s_in_data, s_out_data;
    logic [CTRL_W-1:0] s_in_ctrl, s_out_ctrl;
    logic [1:0]        s_occ;

    logic              n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
    logic [DATA_W-1:0] n_in_data, n_out_data;
    logic [CTRL_W-1:0] n_in_ctrl, n_out_ctrl;
    logic [1:0]        n_occ;

    int compared    = 0;
    int mismatched  = 0;
    int n_occ2_seen = 0;

    logic [BEAT_W-1:0] s_q[$];
    logic [BEAT_W-1:0] n_q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b1)) dut_skid (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_data_i(s_in_data), .in_ctrl_i(s_in_ctrl), .flush_i(s_flush),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl), .occ_o(s_occ)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b0)) dut_single (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
        .in_data_i(n_in_data), .in_ctrl_i(n_in_ctrl), .flush_i(n_flush),
        .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
        .out_data_o(n_out_data), .out_ctrl_o(n_out_ctrl), .occ_o(n_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_skid(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                              input logic f, input logic r);
        s_in_valid = v; s_in_data = d; s_in_ctrl = c; s_flush = f; s_out_ready = r;
    endtask

    task automatic drive_single(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                input logic f, input logic r);
        n_in_valid = v; n_in_data = d; n_in_ctrl = c; n_flush = f; n_out_ready = r;
    endtask

    task automatic apply_stimulus_random();
        drive_skid(1'($urandom_range(0, 1)), DATA_W'({$urandom(), $urandom(), $urandom()}),
                   CTRL_W'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive_single(1'($urandom_range(0, 1)), DATA_W'({$urandom(), $urandom(), $urandom()}),
                     CTRL_W'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Scoreboard sample just before the edge, then advance to 1 time unit after it.
    task automatic tick();
        #1;
        if (!rst) begin
            s_q.delete();
            n_q.delete();
        end else begin
            if (s_out_valid && s_out_ready) begin
                check_output("s_sb_pending", s_q.size() != 0, 1'b1);
                if (s_q.size() != 0) check_output("s_sb_beat", {s_out_data, s_out_ctrl}, s_q.pop_front());
            end
            if (s_flush) s_q.delete();
            else if (s_in_valid && s_in_ready) s_q.push_back({s_in_data, s_in_ctrl});

            if (n_out_valid && n_out_ready) begin
                check_output("n_sb_pending", n_q.size() != 0, 1'b1);
                if (n_q.size() != 0) check_output("n_sb_beat", {n_out_data, n_out_ctrl}, n_q.pop_front());
            end
            if (n_flush) n_q.delete();
            else if (n_in_valid && n_in_ready) n_q.push_back({n_in_data, n_in_ctrl});

            if (n_occ == 2'd2) n_occ2_seen++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus_random();
        tick();
        apply_stimulus_random();
        tick();
        check_output("rst_s_out_valid", s_out_valid, 1'b0);
        check_output("rst_s_out_data", s_out_data, '0);
        check_output("rst_s_out_ctrl", s_out_ctrl, '0);
        check_output("rst_s_occ", s_occ, 2'd0);
        check_output("rst_s_in_ready", s_in_ready, 1'b1);
        check_output("rst_n_out_valid", n_out_valid, 1'b0);
        check_output("rst_n_out_data", n_out_data, '0);
        check_output("rst_n_out_ctrl", n_out_ctrl, '0);
        check_output("rst_n_occ", n_occ, 2'd0);
        check_output("rst_n_in_ready", n_in_ready, 1'b1);

        rst = 1'b1;
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        drive_single(1'b0, '0, '0, 1'b0, 1'b1);

        $display("[TB] streaming 0x1..0x10 through both instances");
        for (int i = 1; i <= 16; i++) begin
            drive_skid(1'b1, DATA_W'(i), 4'b1010, 1'b0, 1'b1);
            drive_single(1'b1, DATA_W'(i), 4'b1010, 1'b0, 1'b1);
            tick();
            check_output("stream_s_valid", s_out_valid, 1'b1);
            check_output("stream_s_data", s_out_data, DATA_W'(i));
            check_output("stream_s_occ", s_occ, 2'd1);
            check_output("stream_n_valid", n_out_valid, 1'b1);
            check_output("stream_n_data", n_out_data, DATA_W'(i));
        end
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        drive_single(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check_output("drain_s_valid", s_out_valid, 1'b0);
        check_output("drain_s_ctrl", s_out_ctrl, 4'b0000);
        check_output("drain_s_data_hold", s_out_data, DATA_W'(16));
        check_output("drain_s_occ", s_occ, 2'd0);
        check_output("drain_n_valid", n_out_valid, 1'b0);
        check_output("drain_n_ctrl", n_out_ctrl, 4'b0000);

        $display("[TB] skid absorb with 3-cycle downstream stall");
        drive_skid(1'b1, DATA_W'('hA0), 4'b0101, 1'b0, 1'b1);
        tick();
        check_output("skid_a0_out", s_out_data, DATA_W'('hA0));
        drive_skid(1'b1, DATA_W'('hA1), 4'b0101, 1'b0, 1'b0);
        tick();
        check_output("skid_occ2", s_occ, 2'd2);
        check_output("skid_ready_low", s_in_ready, 1'b0);
        check_output("skid_hold_a0", s_out_data, DATA_W'('hA0));
        drive_skid(1'b1, DATA_W'('hA2), 4'b0101, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output("skid_stall_ready", s_in_ready, 1'b0);
            check_output("skid_stall_occ", s_occ, 2'd2);
            check_output("skid_stall_data", s_out_data, DATA_W'('hA0));
        end
        drive_skid(1'b1, DATA_W'('hA2), 4'b0101, 1'b0, 1'b1);
        tick();
        check_output("skid_a1_out", s_out_data, DATA_W'('hA1));
        check_output("skid_a1_valid", s_out_valid, 1'b1);
        check_output("skid_ready_back", s_in_ready, 1'b1);
        check_output("skid_occ1", s_occ, 2'd1);
        tick();
        check_output("skid_a2_out", s_out_data, DATA_W'('hA2));
        check_output("skid_a2_valid", s_out_valid, 1'b1);
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check_output("skid_drained", s_out_valid, 1'b0);

        $display("[TB] flush while in SKID with 0xBB offered");
        drive_skid(1'b1, DATA_W'('hC0), 4'b1100, 1'b0, 1'b1);
        tick();
        drive_skid(1'b1, DATA_W'('hC1), 4'b1100, 1'b0, 1'b0);
        tick();
        check_output("flush_pre_occ", s_occ, 2'd2);
        drive_skid(1'b1, DATA_W'('hBB), 4'b1111, 1'b1, 1'b0);
        tick();
        check_output("flush_valid", s_out_valid, 1'b0);
        check_output("flush_ctrl", s_out_ctrl, 4'b0000);
        check_output("flush_occ", s_occ, 2'd0);
        check_output("flush_ready", s_in_ready, 1'b1);
        check_output("flush_data_hold", s_out_data, DATA_W'('hC0));
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check_output("flush_no_bb", s_out_valid, 1'b0);

        $display("[TB] flush coinciding with out_fire in FULL");
        drive_skid(1'b1, DATA_W'('h55), 4'b0110, 1'b0, 1'b1);
        tick();
        check_output("ff_ctrl_loaded", s_out_ctrl, 4'b0110);
        drive_skid(1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        check_output("ff_occ", s_occ, 2'd0);
        check_output("ff_ctrl", s_out_ctrl, 4'b0000);
        check_output("ff_data_hold", s_out_data, DATA_W'('h55));
        check_output("ff_valid", s_out_valid, 1'b0);
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check_output("ff_no_dup", s_out_valid, 1'b0);

        $display("[TB] single-register back-pressure");
        drive_single(1'b1, DATA_W'('hD0), 4'b1001, 1'b0, 1'b1);
        tick();
        drive_single(1'b1, DATA_W'('hD1), 4'b1001, 1'b0, 1'b0);
        #1;
        check_output("single_ready_low", n_in_ready, 1'b0);
        tick();
        check_output("single_hold_data", n_out_data, DATA_W'('hD0));
        check_output("single_occ", n_occ, 2'd1);
        drive_single(1'b1, DATA_W'('hD1), 4'b1001, 1'b0, 1'b1);
        #1;
        check_output("single_ready_high", n_in_ready, 1'b1);
        tick();
        check_output("single_replaced", n_out_data, DATA_W'('hD1));
        check_output("single_valid", n_out_valid, 1'b1);
        drive_single(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check_output("single_drained", n_out_valid, 1'b0);

        $display("[TB] asynchronous reset while in SKID");
        drive_skid(1'b1, DATA_W'('hE0), 4'b0011, 1'b0, 1'b1);
        tick();
        drive_skid(1'b1, DATA_W'('hE1), 4'b0011, 1'b0, 1'b0);
        tick();
        check_output("arst_pre_occ", s_occ, 2'd2);
        rst = 1'b0;
        #1;
        check_output("arst_valid", s_out_valid, 1'b0);
        check_output("arst_data", s_out_data, '0);
        check_output("arst_ctrl", s_out_ctrl, '0);
        check_output("arst_occ", s_occ, 2'd0);
        check_output("arst_ready", s_in_ready, 1'b1);
        drive_skid(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check_output("arst_after_valid", s_out_valid, 1'b0);

        check_output("s_sb_drained", s_q.size(), 0);
        check_output("n_sb_drained", n_q.size(), 0);
        check_output("n_occ_never_2", n_occ2_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
